button_debounce_multi: RTL and testbench



---
 rtl/button_debounce_multi_pkg.sv | 19 +
 rtl/button_debounce_chan.sv | 99 +++++++++
 rtl/button_debounce_multi.sv | 36 +++
 tb/tb_button_debounce_multi.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/button_debounce_multi_pkg.sv
// Shared constants and helpers for the multi-channel button debouncer.
package button_debounce_multi_pkg;

  // Minimum bit width able to hold values 0..v-1, never less than 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(v)) r = i + 1;
    end
    return (r == 0) ? 1 : r;
  endfunction

  // Pin level seen when nobody touches the button.
  function automatic logic released_pin(input bit active_low);
    return active_low ? 1'b1 : 1'b0;
  endfunction

endpackage

// File: rtl/button_debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, edge pulses and
// a one-shot long-press detector.
module button_debounce_chan
  import button_debounce_multi_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 255,
  parameter int unsigned LONG_CYCLES     = 65535,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned DCNT_W   = clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned LCNT_W   = clog2(LONG_CYCLES + 1);
  localparam logic        RELEASED = released_pin(ACTIVE_LOW);

  logic              s1_q, s2_q;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              rel_q, rel_d;
  logic              long_q, long_d;
  logic              fired_q, fired_d;
  logic [DCNT_W-1:0] dcnt_q, dcnt_d;
  logic [LCNT_W-1:0] lcnt_q, lcnt_d;
  logic              p;

  // Normalised sample: 1 means pressed regardless of pin polarity.
  assign p = s2_q ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q    <= RELEASED;
      s2_q    <= RELEASED;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
      fired_q <= 1'b0;
      dcnt_q  <= '0;
      lcnt_q  <= '0;
    end else begin
      s1_q    <= pin;
      s2_q    <= s1_q;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
      fired_q <= fired_d;
      dcnt_q  <= dcnt_d;
      lcnt_q  <= lcnt_d;
    end
  end

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    fired_d = fired_q;
    dcnt_d  = dcnt_q;
    lcnt_d  = lcnt_q;

    if (p == level_q) begin
      dcnt_d = '0;
    end else if (dcnt_q == DCNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = p;
      dcnt_d  = '0;
      press_d = p;
      rel_d   = ~p;
    end else begin
      dcnt_d = dcnt_q + DCNT_W'(1);
    end

    // lcnt holds at its threshold once fired, so no wrap and no auto-repeat.
    if (!level_q) begin
      lcnt_d  = '0;
      fired_d = 1'b0;
    end else if (!fired_q) begin
      if (lcnt_q == LCNT_W'(LONG_CYCLES - 1)) begin
        long_d  = 1'b1;
        fired_d = 1'b1;
      end else begin
        lcnt_d = lcnt_q + LCNT_W'(1);
      end
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = rel_q;
  assign long_press    = long_q;

endmodule

// File: rtl/button_debounce_multi.sv
// Multi-channel push-button debouncer; replicates one independent channel per pin.
module button_debounce_multi
  import button_debounce_multi_pkg::*;
#(
  parameter int unsigned N_BTN           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 255,
  parameter int unsigned LONG_CYCLES     = 65535,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] level,
  output logic [N_BTN-1:0] press,
  // 'release' is a reserved word, hence the suffix.
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_press
);

  for (genvar g = 0; g < N_BTN; g++) begin : g_chan
    button_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .pin          (btn_in[g]),
      .level        (level[g]),
      .press        (press[g]),
      .release_pulse(release_pulse[g]),
      .long_press   (long_press[g])
    );
  end

endmodule

// File: tb/tb_button_debounce_multi.sv
// Directed bench for button_debounce_multi with an event scoreboard.
module tb_button_debounce_multi;

  localparam int unsigned NB = 2;
  localparam int unsigned DC = 4;
  localparam int unsigned LC = 10;
  localparam int LAT = 2 + DC;  // pin driven after edge k shows after edge k+LAT

  typedef struct {
    int at;
    int ch;
    int kind;  // 0 press, 1 release, 2 long
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic [NB-1:0] btn_in, level, press, rel, long_press;
  logic [NB-1:0] btn_hi, level_hi, press_hi, rel_hi, long_hi;

  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  ev_t  q[$];
  logic [NB-1:0] exp_level = '0;

  always #5 clk = ~clk;

  button_debounce_multi #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC), .ACTIVE_LOW(1'b1)
  ) u_dut (
    .clk(clk), .rst(rst), .btn_in(btn_in), .level(level), .press(press),
    .release_pulse(rel), .long_press(long_press)
  );

  button_debounce_multi #(
    .N_BTN(NB), .DEBOUNCE_CYCLES(DC), .LONG_CYCLES(LC), .ACTIVE_LOW(1'b0)
  ) u_dut_hi (
    .clk(clk), .rst(rst), .btn_in(btn_hi), .level(level_hi), .press(press_hi),
    .release_pulse(rel_hi), .long_press(long_hi)
  );

  task automatic push(input int at, input int ch, input int kind);
    ev_t e;
    e.at = at; e.ch = ch; e.kind = kind;
    q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [NB-1:0] got, input logic [NB-1:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, got, exp);
    end
  endtask

  // Press ch for n cycles, then release; scoreboard gets the resulting pulses.
  task automatic hold_ch(input int ch, input int n);
    int t;
    @(negedge clk);
    btn_in[ch] = 1'b0;
    t = cyc + LAT;
    push(t, ch, 0);
    if (n >= int'(LC)) push(t + int'(LC), ch, 2);
    repeat (n) @(negedge clk);
    btn_in[ch] = 1'b1;
    push(cyc + LAT, ch, 1);
    repeat (LAT + 3) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    q.delete();
    exp_level = '0;
    repeat (n) @(negedge clk);
    rst = 1'b0;
  endtask

  // Scoreboard: pop events due this cycle and compare every output vector.
  always @(posedge clk) begin
    logic [NB-1:0] ep, er, el;
    cyc = cyc + 1;
    #2;
    ep = '0; er = '0; el = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].at == cyc) begin
        case (q[i].kind)
          0: ep[q[i].ch] = 1'b1;
          1: er[q[i].ch] = 1'b1;
          default: el[q[i].ch] = 1'b1;
        endcase
        q.delete(i);
      end
    end
    exp_level = (exp_level | ep) & ~er;
    check("press", press, ep);
    check("release", rel, er);
    check("long_press", long_press, el);
    check("level", level, exp_level);
  end

  initial begin
    int t;
    logic [12:0] bounce;
    rst    = 1'b1;
    btn_in = 2'b00;
    btn_hi = 2'b00;

    // Reset with both buttons held: press on both together after release of rst.
    repeat (3) @(negedge clk);
    check("hi_reset_level", level_hi, 2'b00);
    check("hi_reset_press", press_hi | rel_hi | long_hi, 2'b00);
    rst = 1'b0;
    push(cyc + LAT, 0, 0);
    push(cyc + LAT, 1, 0);
    repeat (8) @(negedge clk);
    btn_in = 2'b11;
    push(cyc + LAT, 0, 1);
    push(cyc + LAT, 1, 1);
    repeat (10) @(negedge clk);

    // Clean press/release, long press, short hold.
    hold_ch(0, 6);
    hold_ch(0, 30);
    hold_ch(0, 8);

    // Bounce: 3 low, 1 high, 3 low, then high -- never accepted.
    bounce = 13'b1111110001000;
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      btn_in[0] = bounce[i];
    end
    // Exactly 4 low samples is enough.
    @(negedge clk);
    btn_in[0] = 1'b0;
    push(cyc + LAT, 0, 0);
    repeat (4) @(negedge clk);
    btn_in[0] = 1'b1;
    push(cyc + LAT, 0, 1);
    repeat (10) @(negedge clk);

    // Reset with dcnt at 3: press aborted, then restarts after reset.
    btn_in[0] = 1'b0;
    repeat (5) @(negedge clk);
    do_reset(3);
    t = cyc + LAT;
    push(t, 0, 0);
    // Reset with lcnt at 8: long press aborted, restarts from the new press.
    repeat (14) @(negedge clk);
    do_reset(2);
    t = cyc + LAT;
    push(t, 0, 0);
    push(t + int'(LC), 0, 2);
    repeat (13) @(negedge clk);
    btn_in[0] = 1'b1;
    push(cyc + LAT, 0, 1);
    repeat (10) @(negedge clk);

    // Active-high instance: released pins gave nothing; rising pin presses.
    check("hi_idle", level_hi | press_hi | rel_hi | long_hi, 2'b00);
    btn_hi[1] = 1'b1;
    repeat (LAT - 1) @(posedge clk);
    #2;
    check("hi_early", press_hi, 2'b00);
    @(posedge clk);
    #2;
    check("hi_press", press_hi, 2'b10);
    check("hi_level", level_hi, 2'b10);
    @(posedge clk);
    #2;
    check("hi_press_done", press_hi, 2'b00);

    repeat (3) @(negedge clk);
    tests++;
    assert (q.size() == 0) else begin
      fails++;
      $error("FAIL pending_events observed=%0d expected=0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
